// File: rtl/uart_rx_dma_pkg.sv
// Purpose: shared types for the UART RX DMA arbiter: FSM state encoding, grant owner, byte-lane decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package uart_rx_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_DMA = 1'b1
  } grant_t;

  // Byte pointer low bits -> Wishbone byte select for a single-byte write.
  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    lane_sel = 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/uart_rx_dma_arbiter_if.sv
// Purpose: one 32-bit Wishbone classic bus (adr/dat/sel/we/cyc out, rdt/ack back).
// Latency: n/a (wires only).
// Backpressure: ack from the slave completes the cycle; master holds cyc until then.
// Modports: master drives the request and samples rdt/ack; slave is the mirror.
interface uart_rx_dma_arbiter_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/uart_rx_dma_fifo.sv
// Purpose: synchronous 8-bit FIFO buffering received UART bytes ahead of the DMA writer.
// Latency: head byte visible on o_dout the cycle after the push; pop is combinational-read.
// Backpressure: push is refused when full unless a pop frees a slot the same cycle.
// Ports: i_wb_clk/i_wb_rst_n; i_push/i_din in; i_pop in; o_dout head; o_full/o_empty/o_level status.
module uart_rx_dma_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     i_wb_clk,
  input  logic                     i_wb_rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  output logic [7:0]               o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (level_q == (AW+1)'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_dout  = mem_q[rd_q];

  assign do_pop  = i_pop && !o_empty;
  // When full, the slot being popped this cycle can take the incoming byte.
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_wb_clk) begin
    if (do_push) begin
      mem_q[wr_q] <= i_din;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_dma_arbiter.sv
// Purpose: shares servant_ram between the SERV CPU port and a DMA path writing UART RX bytes into a byte ring.
// Latency: one registered grant cycle before any bus access (CPU or DMA); each access ends on RAM ack.
// Backpressure: CPU waits on ack; RX bytes are buffered in a FIFO and dropped (sticky o_overflow) when it is full.
// Ports: i_wb_clk, i_wb_rst_n; i_rx_valid/i_rx_data strobe; wb_cpu (slave) CPU bus; wb_mem (master) RAM bus;
//        o_wr_ptr next ring byte address; o_fifo_level; o_overflow/i_ovf_clr; o_irq.
// Option: define UART_RX_DMA_IRQ_EN to drive o_irq with a wrap pulse OR'd with o_overflow; otherwise o_irq is 0.
module uart_rx_dma_arbiter
  import uart_rx_dma_pkg::*;
#(
  parameter logic [31:0] RING_BASE  = 32'h0000_1000,
  parameter int          RING_BYTES = 1024,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                          i_wb_clk,
  input  logic                          i_wb_rst_n,
  input  logic                          i_rx_valid,
  input  logic [7:0]                    i_rx_data,
  uart_rx_dma_arbiter_if.slave          wb_cpu,
  uart_rx_dma_arbiter_if.master         wb_mem,
  output logic [31:0]                   o_wr_ptr,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow,
  input  logic                          i_ovf_clr,
  output logic                          o_irq
);

  localparam logic [31:0] RING_LAST = RING_BASE + 32'(RING_BYTES) - 32'd1;

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       cpu_req;
  logic       dma_req;
  logic       dma_done;
  logic       at_ring_end;
  logic       rx_drop;

  uart_rx_dma_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_wb_clk   (i_wb_clk),
    .i_wb_rst_n (i_wb_rst_n),
    .i_push     (i_rx_valid),
    .i_din      (i_rx_data),
    .i_pop      (fifo_pop),
    .o_dout     (fifo_head),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_level    (o_fifo_level)
  );

  assign cpu_req     = wb_cpu.cyc;
  assign dma_req     = !fifo_empty;
  assign dma_done    = (state_q == ST_DMA) && wb_mem.ack;
  assign at_ring_end = (o_wr_ptr == RING_LAST);
  // A pop in the same cycle frees a slot, so the byte is kept.
  assign rx_drop     = i_rx_valid && fifo_full && !fifo_pop;

  // Read data is a straight pass-through; only ack is gated by the grant.
  assign wb_cpu.rdt = wb_mem.rdt;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_CPU;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    fifo_pop     = 1'b0;
    wb_mem.adr   = '0;
    wb_mem.dat   = '0;
    wb_mem.sel   = '0;
    wb_mem.we    = 1'b0;
    wb_mem.cyc   = 1'b0;
    wb_cpu.ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A full FIFO jumps the queue so RX bytes are not lost to a busy CPU.
        if (dma_req && fifo_full) begin
          state_d = ST_DMA;
        end else if (cpu_req && dma_req) begin
          state_d = (last_grant_q == GRANT_CPU) ? ST_DMA : ST_CPU;
        end else if (cpu_req) begin
          state_d = ST_CPU;
        end else if (dma_req) begin
          state_d = ST_DMA;
        end
      end
      ST_CPU: begin
        wb_mem.adr = wb_cpu.adr;
        wb_mem.dat = wb_cpu.dat;
        wb_mem.sel = wb_cpu.sel;
        wb_mem.we  = wb_cpu.we;
        wb_mem.cyc = wb_cpu.cyc;
        wb_cpu.ack = wb_mem.ack;
        if (!wb_cpu.cyc) begin
          // Abandoned cycle: release the bus without touching fairness state.
          state_d = ST_IDLE;
        end else if (wb_mem.ack) begin
          state_d      = ST_IDLE;
          last_grant_d = GRANT_CPU;
        end
      end
      ST_DMA: begin
        wb_mem.adr = {o_wr_ptr[31:2], 2'b00};
        wb_mem.dat = {4{fifo_head}};
        wb_mem.sel = lane_sel(o_wr_ptr[1:0]);
        wb_mem.we  = 1'b1;
        wb_mem.cyc = 1'b1;
        if (wb_mem.ack) begin
          fifo_pop     = 1'b1;
          state_d      = ST_IDLE;
          last_grant_d = GRANT_DMA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_wr_ptr <= RING_BASE;
    end else if (dma_done) begin
      o_wr_ptr <= at_ring_end ? RING_BASE : (o_wr_ptr + 32'd1);
    end
  end

  // Setting has priority over clearing so a drop is never lost.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_overflow <= 1'b0;
    end else if (rx_drop) begin
      o_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      o_overflow <= 1'b0;
    end
  end

`ifdef UART_RX_DMA_IRQ_EN
  // Wrap pulse coincides with the ack of the last byte in the ring.
  assign o_irq = (dma_done && at_ring_end) || o_overflow;
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_dma_arbiter.sv
// Purpose: self-checking bench for uart_rx_dma_arbiter with a queue scoreboard on the RAM bus.
// Latency: n/a.
// Backpressure: RAM ack can be withheld to stall the DMA path.
module tb_uart_rx_dma_arbiter;

  localparam logic [31:0] RDT_VAL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        ovf_clr;
  logic [31:0] wr_ptr;
  logic [3:0]  level;
  logic        overflow;
  logic        irq;
  logic        ack_en;

  always #5 clk = ~clk;

  uart_rx_dma_arbiter_if cpu_bus ();
  uart_rx_dma_arbiter_if mem_bus ();

  uart_rx_dma_arbiter #(
    .RING_BASE  (32'h0000_1000),
    .RING_BYTES (16),
    .FIFO_DEPTH (8)
  ) dut (
    .i_wb_clk     (clk),
    .i_wb_rst_n   (rst_n),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .wb_cpu       (cpu_bus.slave),
    .wb_mem       (mem_bus.master),
    .o_wr_ptr     (wr_ptr),
    .o_fifo_level (level),
    .o_overflow   (overflow),
    .i_ovf_clr    (ovf_clr),
    .o_irq        (irq)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        is_cpu;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   irq_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic exp_dma(input logic [31:0] adr, input logic [3:0] sel, input logic [7:0] b);
    txn_t t;
    t.adr = adr; t.dat = {4{b}}; t.sel = sel; t.we = 1'b1; t.is_cpu = 1'b0;
    exp_q.push_back(t);
  endtask

  task automatic exp_cpu(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic we);
    txn_t t;
    t.adr = adr; t.dat = dat; t.sel = sel; t.we = we; t.is_cpu = 1'b1;
    exp_q.push_back(t);
  endtask

  // RAM model: single-cycle ack pulse two time units after the edge that raised cyc.
  initial begin
    mem_bus.ack = 1'b0;
    mem_bus.rdt = RDT_VAL;
    forever begin
      @(posedge clk);
      #2;
      mem_bus.ack = ack_en && mem_bus.cyc && !mem_bus.ack;
    end
  end

  // Monitor: every completed RAM cycle is matched against the head of the scoreboard.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (rst_n && irq && !overflow) irq_pulses++;
      if (rst_n && mem_bus.cyc && mem_bus.ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: actual adr=%h sel=%b required none", mem_bus.adr, mem_bus.sel);
        end else begin
          t = exp_q.pop_front();
          check("txn_adr", mem_bus.adr, t.adr);
          check("txn_sel", 32'(mem_bus.sel), 32'(t.sel));
          check("txn_we", 32'(mem_bus.we), 32'(t.we));
          check("txn_dat", mem_bus.dat, t.dat);
          check("cpu_ack_owner", 32'(cpu_bus.ack), 32'(t.is_cpu));
          if (t.is_cpu && !t.we) check("cpu_rdt", cpu_bus.rdt, RDT_VAL);
        end
      end
    end
  end

  task automatic do_reset;
    rst_n = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; ovf_clr = 1'b0;
    cpu_bus.cyc = 1'b0; cpu_bus.we = 1'b0; cpu_bus.adr = '0; cpu_bus.dat = '0; cpu_bus.sel = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic cpu_start(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic we);
    cpu_bus.adr = adr; cpu_bus.dat = dat; cpu_bus.sel = sel; cpu_bus.we = we; cpu_bus.cyc = 1'b1;
  endtask

  task automatic cpu_wait_end(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cpu_bus.ack) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
    @(posedge clk); #1;
    cpu_bus.cyc = 1'b0; cpu_bus.we = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] p;
    logic [3:0]  s;
    logic        seen;
    ack_en = 1'b1;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_mem_cyc", 32'(mem_bus.cyc), 32'd0);
    check("rst_mem_adr", mem_bus.adr, 32'd0);
    check("rst_mem_sel", 32'(mem_bus.sel), 32'd0);
    check("rst_cpu_ack", 32'(cpu_bus.ack), 32'd0);
    check("rst_wr_ptr", wr_ptr, 32'h0000_1000);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);

    // 1: single byte
    do_reset();
    exp_dma(32'h1000, 4'b0001, 8'hA5);
    send_byte(8'hA5);
    wait_drain("t1_drain");
    check("t1_wr_ptr", wr_ptr, 32'h0000_1001);

    // 2: five bytes across a word boundary
    do_reset();
    exp_dma(32'h1000, 4'b0001, 8'h01);
    exp_dma(32'h1000, 4'b0010, 8'h02);
    exp_dma(32'h1000, 4'b0100, 8'h03);
    exp_dma(32'h1000, 4'b1000, 8'h04);
    exp_dma(32'h1004, 4'b0001, 8'h05);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    wait_drain("t2_drain");
    check("t2_wr_ptr", wr_ptr, 32'h0000_1005);

    // 3: 16-byte ring wraps on the 17th byte
    do_reset();
    irq_pulses = 0;
    for (int i = 0; i < 17; i++) begin
      p = 32'(i % 16);
      s = 4'(1 << (i % 4));
      exp_dma(32'h1000 + (p & 32'hFFFF_FFFC), s, 8'(8'h30 + i));
    end
    for (int i = 0; i < 17; i++) send_byte(8'(8'h30 + i));
    wait_drain("t3_drain");
    check("t3_wr_ptr", wr_ptr, 32'h0000_1001);
`ifdef UART_RX_DMA_IRQ_EN
    check("t3_irq_pulses", 32'(irq_pulses), 32'd1);
`else
    check("t3_irq_pulses", 32'(irq_pulses), 32'd0);
`endif

    // 4: RAM stalled, FIFO_DEPTH+1 bytes -> last one dropped
    do_reset();
    ack_en = 1'b0;
    for (int i = 0; i < 8; i++) exp_dma(32'h1000 + 32'(i & 4), 4'(1 << (i % 4)), 8'(8'h10 + i));
    for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i));
    repeat (2) @(negedge clk);
    check("t4_level_full", 32'(level), 32'd8);
    check("t4_overflow_set", 32'(overflow), 32'd1);
    check("t4_stalled_adr", mem_bus.adr, 32'h0000_1000);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    check("t4_overflow_clr", 32'(overflow), 32'd0);
    ack_en = 1'b1;
    wait_drain("t4_drain");
    check("t4_wr_ptr", wr_ptr, 32'h0000_1008);
    check("t4_level_empty", 32'(level), 32'd0);

    // 5a: CPU read in flight when a byte arrives -> CPU completes first
    do_reset();
    exp_cpu(32'h200, 32'h0, 4'hF, 1'b0);
    exp_dma(32'h1000, 4'b0001, 8'h77);
    @(posedge clk); #1;
    cpu_start(32'h200, 32'h0, 4'hF, 1'b0);
    fork
      send_byte(8'h77);
      cpu_wait_end("t5a_cpu_ack");
    join
    wait_drain("t5a_drain");
    // 5b: CPU write leaves last_grant=CPU; then both request together -> DMA first
    exp_cpu(32'h204, 32'h1234_5678, 4'hF, 1'b1);
    @(posedge clk); #1;
    cpu_start(32'h204, 32'h1234_5678, 4'hF, 1'b1);
    cpu_wait_end("t5b_cpu_write_ack");
    exp_dma(32'h1000, 4'b0010, 8'h88);
    exp_cpu(32'h208, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'h88;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    cpu_start(32'h208, 32'h0, 4'hF, 1'b0);
    cpu_wait_end("t5b_cpu_read_ack");
    wait_drain("t5b_drain");
    check("t5_wr_ptr", wr_ptr, 32'h0000_1002);

    // 6: reset asserted in the middle of a DMA cycle
    do_reset();
    exp_dma(32'h1000, 4'b0001, 8'h41);
    exp_dma(32'h1000, 4'b0010, 8'h42);
    send_byte(8'h41);
    send_byte(8'h42);
    wait_drain("t6_pre_drain");
    ack_en = 1'b0;
    send_byte(8'h43);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_bus.cyc) seen = 1'b1;
    end
    check("t6_dma_started", 32'(seen), 32'd1);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_mem_cyc", 32'(mem_bus.cyc), 32'd0);
    check("t6_rst_wr_ptr", wr_ptr, 32'h0000_1000);
    check("t6_rst_level", 32'(level), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    ack_en = 1'b1;
    exp_dma(32'h1000, 4'b0001, 8'h44);
    send_byte(8'h44);
    wait_drain("t6_post_drain");
    check("t6_wr_ptr", wr_ptr, 32'h0000_1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
